// File: rtl/decode_stage.sv
// Registered instruction-decode stage: decodes one instruction per accept,
// holds it behind a valid/ready handshake and stalls on load-use hazards.
module decode_stage #(
    parameter int DATA_W     = 32,
    parameter int EXT_ISA    = 1,
    parameter int ZEXT_LOGIC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              inValid,
    output logic              inReady,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] pcIn,
    output logic              outValid,
    input  logic              outReady,
    output logic [DATA_W-1:0] pcOut,
    output logic [25:0]       jAddr,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        regWAddr,
    output logic [2:0]        op,
    output logic [2:0]        pcSrcCtrl,
    output logic [1:0]        regDInCtrl,
    output logic              regWe,
    output logic              dmWe,
    output logic              aluBSrcCtrl,
    output logic              illegal,
    output logic [DATA_W-1:0] imm
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_SLT = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_NOR = 3'd6;
    localparam logic [2:0] OP_OR  = 3'd7;

    localparam logic [2:0] PC_INC4 = 3'd0;
    localparam logic [2:0] PC_J    = 3'd1;
    localparam logic [2:0] PC_JR   = 3'd2;
    localparam logic [2:0] PC_BNE  = 3'd3;
    localparam logic [2:0] PC_BEQ  = 3'd4;

    localparam logic [1:0] RD_ALU = 2'd0;
    localparam logic [1:0] RD_DM  = 2'd1;
    localparam logic [1:0] RD_JAL = 2'd2;

    logic        ext;
    logic [5:0]  opc;
    logic [5:0]  fn;
    logic        d_we;
    logic        d_dm;
    logic [2:0]  d_op;
    logic [2:0]  d_pc;
    logic [1:0]  d_rdin;
    logic        d_alub;
    logic [4:0]  d_wr;
    logic        d_ill;
    logic        d_zext;
    logic        d_lw;
    logic        d_ialu;
    logic [DATA_W-1:0] d_imm;
    logic        uses_rt;
    logic        hazard;
    logic        accept;
    logic        held_lw;

    assign ext = (EXT_ISA != 0);
    assign opc = instr[31:26];
    assign fn  = instr[5:0];

    always_comb begin
        d_we   = 1'b0;
        d_dm   = 1'b0;
        d_op   = OP_ADD;
        d_pc   = PC_INC4;
        d_rdin = RD_ALU;
        d_alub = 1'b0;
        d_wr   = 5'd0;
        d_ill  = 1'b0;
        d_zext = 1'b0;
        d_lw   = 1'b0;
        d_ialu = 1'b0;
        unique case (opc)
            6'h23: begin
                d_we   = 1'b1;
                d_rdin = RD_DM;
                d_alub = 1'b1;
                d_wr   = instr[20:16];
                d_lw   = 1'b1;
            end
            6'h2b: begin
                d_dm   = 1'b1;
                d_alub = 1'b1;
            end
            6'h02: d_pc = PC_J;
            6'h03: begin
                d_we   = 1'b1;
                d_pc   = PC_J;
                d_rdin = RD_JAL;
                d_wr   = 5'd31;
            end
            6'h05: begin
                d_op = OP_SUB;
                d_pc = PC_BNE;
            end
            6'h04: begin
                d_op  = OP_SUB;
                d_pc  = PC_BEQ;
                d_ill = !ext;
            end
            6'h08: d_ialu = 1'b1;
            6'h0e: begin
                d_ialu = 1'b1;
                d_op   = OP_XOR;
                d_zext = 1'b1;
            end
            6'h0a: begin
                d_ialu = 1'b1;
                d_op   = OP_SLT;
                d_ill  = !ext;
            end
            6'h0c: begin
                d_ialu = 1'b1;
                d_op   = OP_AND;
                d_zext = 1'b1;
                d_ill  = !ext;
            end
            6'h0d: begin
                d_ialu = 1'b1;
                d_op   = OP_OR;
                d_zext = 1'b1;
                d_ill  = !ext;
            end
            6'h00: begin
                d_wr = instr[15:11];
                unique case (fn)
                    6'h00, 6'h20: d_we = 1'b1;
                    6'h22: begin
                        d_we = 1'b1;
                        d_op = OP_SUB;
                    end
                    6'h2a: begin
                        d_we = 1'b1;
                        d_op = OP_SLT;
                    end
                    6'h24: begin
                        d_we  = 1'b1;
                        d_op  = OP_AND;
                        d_ill = !ext;
                    end
                    6'h25: begin
                        d_we  = 1'b1;
                        d_op  = OP_OR;
                        d_ill = !ext;
                    end
                    6'h26: begin
                        d_we  = 1'b1;
                        d_op  = OP_XOR;
                        d_ill = !ext;
                    end
                    6'h27: begin
                        d_we  = 1'b1;
                        d_op  = OP_NOR;
                        d_ill = !ext;
                    end
                    6'h08: d_pc = PC_JR;
                    default: d_ill = 1'b1;
                endcase
            end
            default: d_ill = 1'b1;
        endcase
        if (d_ialu) begin
            d_we   = 1'b1;
            d_alub = 1'b1;
            d_wr   = instr[20:16];
        end
        if (d_ill) begin
            d_we = 1'b0;
            d_dm = 1'b0;
            d_pc = PC_INC4;
        end
        if (d_wr == 5'd0) d_we = 1'b0;
    end

    always_comb begin
        if (d_zext && (ZEXT_LOGIC != 0))
            d_imm = {{(DATA_W-16){1'b0}}, instr[15:0]};
        else
            d_imm = {{(DATA_W-16){instr[15]}}, instr[15:0]};
    end

    // Only R-type, stores and compare-branches read rt as an operand.
    assign uses_rt = (opc == 6'h00) || (opc == 6'h2b) || (opc == 6'h05)
                   || ((opc == 6'h04) && ext);

    assign hazard = inValid && outValid && held_lw && (regWAddr != 5'd0)
                  && ((regWAddr == instr[25:21])
                      || ((regWAddr == instr[20:16]) && uses_rt));

    assign inReady = !flush && !hazard && (!outValid || outReady);
    assign accept  = inValid && inReady;

    always_ff @(posedge clk) begin
        if (rst) begin
            outValid    <= 1'b0;
            held_lw     <= 1'b0;
            pcOut       <= '0;
            jAddr       <= '0;
            rs          <= '0;
            rt          <= '0;
            rd          <= '0;
            regWAddr    <= '0;
            op          <= '0;
            pcSrcCtrl   <= '0;
            regDInCtrl  <= '0;
            regWe       <= 1'b0;
            dmWe        <= 1'b0;
            aluBSrcCtrl <= 1'b0;
            illegal     <= 1'b0;
            imm         <= '0;
        end else if (flush) begin
            outValid <= 1'b0;
        end else if (accept) begin
            outValid    <= 1'b1;
            held_lw     <= d_lw;
            pcOut       <= pcIn;
            jAddr       <= instr[25:0];
            rs          <= instr[25:21];
            rt          <= instr[20:16];
            rd          <= instr[15:11];
            regWAddr    <= d_wr;
            op          <= d_op;
            pcSrcCtrl   <= d_pc;
            regDInCtrl  <= d_rdin;
            regWe       <= d_we;
            dmWe        <= d_dm;
            aluBSrcCtrl <= d_alub;
            illegal     <= d_ill;
            imm         <= d_imm;
        end else if (outValid && outReady) begin
            outValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage; a second instance runs with the
// extended opcode set disabled.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        inValid;
    logic        outReady;
    logic [31:0] instr;
    logic [31:0] pcIn;

    logic        inReady, outValid, regWe, dmWe, aluBSrcCtrl, illegal;
    logic [31:0] pcOut, imm;
    logic [25:0] jAddr;
    logic [4:0]  rs, rt, rd, regWAddr;
    logic [2:0]  op, pcSrcCtrl;
    logic [1:0]  regDInCtrl;

    logic        x_inReady, x_outValid, x_regWe, x_dmWe, x_aluB, x_illegal;
    logic [31:0] x_pcOut, x_imm;
    logic [25:0] x_jAddr;
    logic [4:0]  x_rs, x_rt, x_rd, x_regWAddr;
    logic [2:0]  x_op, x_pcSrc;
    logic [1:0]  x_regDIn;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    decode_stage #(.DATA_W(32), .EXT_ISA(1), .ZEXT_LOGIC(1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .inValid(inValid), .inReady(inReady),
        .instr(instr), .pcIn(pcIn),
        .outValid(outValid), .outReady(outReady),
        .pcOut(pcOut), .jAddr(jAddr),
        .rs(rs), .rt(rt), .rd(rd), .regWAddr(regWAddr),
        .op(op), .pcSrcCtrl(pcSrcCtrl), .regDInCtrl(regDInCtrl),
        .regWe(regWe), .dmWe(dmWe), .aluBSrcCtrl(aluBSrcCtrl),
        .illegal(illegal), .imm(imm)
    );

    decode_stage #(.DATA_W(32), .EXT_ISA(0), .ZEXT_LOGIC(1)) dut_base (
        .clk(clk), .rst(rst), .flush(flush),
        .inValid(inValid), .inReady(x_inReady),
        .instr(instr), .pcIn(pcIn),
        .outValid(x_outValid), .outReady(outReady),
        .pcOut(x_pcOut), .jAddr(x_jAddr),
        .rs(x_rs), .rt(x_rt), .rd(x_rd), .regWAddr(x_regWAddr),
        .op(x_op), .pcSrcCtrl(x_pcSrc), .regDInCtrl(x_regDIn),
        .regWe(x_regWe), .dmWe(x_dmWe), .aluBSrcCtrl(x_aluB),
        .illegal(x_illegal), .imm(x_imm)
    );

    localparam logic [31:0] V_INSTR [8] = '{
        32'h00223824, 32'h03e00008, 32'h0C000010, 32'hFC000000,
        32'h0022402a, 32'h10220004, 32'hAC220004, 32'h00010020
    };
    localparam logic [2:0] V_OP  [8] = '{3'd4, 3'd0, 3'd0, 3'd0, 3'd3, 3'd1, 3'd0, 3'd0};
    localparam logic [2:0] V_PC  [8] = '{3'd0, 3'd2, 3'd1, 3'd0, 3'd0, 3'd4, 3'd0, 3'd0};
    localparam logic [1:0] V_RD  [8] = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    localparam logic       V_WE  [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [4:0] V_WR  [8] = '{5'd7, 5'd0, 5'd31, 5'd0, 5'd8, 5'd0, 5'd0, 5'd0};
    localparam logic       V_ILL [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic       V_DM  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
        instr = 32'h0; pcIn = 32'h0;
        step();
        step();
        tests++;
        if (outValid !== 1'b0 || regWe !== 1'b0 || imm !== 32'h0 || pcOut !== 32'h0) begin
            fails++;
            $display("FAIL reset_state: outValid=%b regWe=%b imm=%h pcOut=%h want 0", outValid, regWe, imm, pcOut);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (inReady !== 1'b1) begin
            fails++;
            $display("FAIL reset_inready: got %b want 1", inReady);
        end
    endtask

    task automatic test_addi();
        instr = 32'h2022ffff; pcIn = 32'h100; inValid = 1'b1; outReady = 1'b1;
        step();
        inValid = 1'b0;
        tests++;
        if (outValid !== 1'b1 || regWAddr !== 5'd2 || imm !== 32'hffffffff || op !== 3'd0
            || aluBSrcCtrl !== 1'b1 || regWe !== 1'b1 || pcOut !== 32'h100 || illegal !== 1'b0) begin
            fails++;
            $display("FAIL addi: v=%b wr=%0d imm=%h op=%0d alub=%b we=%b pc=%h ill=%b want 1 2 ffffffff 0 1 1 100 0",
                     outValid, regWAddr, imm, op, aluBSrcCtrl, regWe, pcOut, illegal);
        end
        step();
        tests++;
        if (outValid !== 1'b0) begin
            fails++;
            $display("FAIL addi_drain: outValid=%b want 0", outValid);
        end
    endtask

    task automatic test_reset_mid();
        instr = 32'h2022ffff; pcIn = 32'h140; inValid = 1'b1; outReady = 1'b0;
        step();
        tests++;
        if (outValid !== 1'b1) begin
            fails++;
            $display("FAIL midreset_pre: outValid=%b want 1", outValid);
        end
        inValid = 1'b0; rst = 1'b1;
        step();
        tests++;
        if (outValid !== 1'b0 || regWe !== 1'b0 || imm !== 32'h0) begin
            fails++;
            $display("FAIL midreset: outValid=%b regWe=%b imm=%h want 0 0 0", outValid, regWe, imm);
        end
        rst = 1'b0; outReady = 1'b1;
        #1;
        tests++;
        if (inReady !== 1'b1) begin
            fails++;
            $display("FAIL midreset_inready: got %b want 1", inReady);
        end
    endtask

    task automatic test_load_use();
        instr = 32'h8C230000; pcIn = 32'h180; inValid = 1'b1; outReady = 1'b1;
        step();
        instr = 32'h00652020; pcIn = 32'h184;
        #1;
        tests++;
        if (inReady !== 1'b0) begin
            fails++;
            $display("FAIL loaduse_stall: inReady=%b want 0", inReady);
        end
        step();
        tests++;
        if (outValid !== 1'b0 || inReady !== 1'b1) begin
            fails++;
            $display("FAIL loaduse_bubble: outValid=%b inReady=%b want 0 1", outValid, inReady);
        end
        step();
        tests++;
        if (outValid !== 1'b1 || regWAddr !== 5'd4 || regWe !== 1'b1 || pcOut !== 32'h184) begin
            fails++;
            $display("FAIL loaduse_accept: v=%b wr=%0d we=%b pc=%h want 1 4 1 184", outValid, regWAddr, regWe, pcOut);
        end
        // LW r3 followed by ADDI writing r3: rt is not a source, no stall
        instr = 32'h8C230000; pcIn = 32'h188;
        step();
        instr = 32'h20230005; pcIn = 32'h18c;
        #1;
        tests++;
        if (inReady !== 1'b1) begin
            fails++;
            $display("FAIL loaduse_rt_dest: inReady=%b want 1", inReady);
        end
        step();
        instr = 32'h8C200000; pcIn = 32'h190;
        step();
        tests++;
        if (regWe !== 1'b0 || regWAddr !== 5'd0 || outValid !== 1'b1) begin
            fails++;
            $display("FAIL lw_r0: regWe=%b wr=%0d v=%b want 0 0 1", regWe, regWAddr, outValid);
        end
        instr = 32'h00052020; pcIn = 32'h194;
        #1;
        tests++;
        if (inReady !== 1'b1) begin
            fails++;
            $display("FAIL lw_r0_nostall: inReady=%b want 1", inReady);
        end
        step();
        inValid = 1'b0;
        tests++;
        if (outValid !== 1'b1 || regWAddr !== 5'd4 || pcOut !== 32'h194) begin
            fails++;
            $display("FAIL lw_r0_next: v=%b wr=%0d pc=%h want 1 4 194", outValid, regWAddr, pcOut);
        end
        step();
    endtask

    task automatic test_backpressure();
        instr = 32'h2022ffff; pcIn = 32'h200; inValid = 1'b1; outReady = 1'b1;
        step();
        outReady = 1'b0; instr = 32'h38268001; pcIn = 32'h204;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if (inReady !== 1'b0 || outValid !== 1'b1 || regWAddr !== 5'd2 || pcOut !== 32'h200) begin
                fails++;
                $display("FAIL bp_hold%0d: rdy=%b v=%b wr=%0d pc=%h want 0 1 2 200", i, inReady, outValid, regWAddr, pcOut);
            end
            step();
        end
        outReady = 1'b1;
        #1;
        tests++;
        if (inReady !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: inReady=%b want 1", inReady);
        end
        step();
        inValid = 1'b0;
        tests++;
        if (outValid !== 1'b1 || regWAddr !== 5'd6 || imm !== 32'h00008001 || op !== 3'd2 || pcOut !== 32'h204) begin
            fails++;
            $display("FAIL bp_xori: v=%b wr=%0d imm=%h op=%0d pc=%h want 1 6 00008001 2 204", outValid, regWAddr, imm, op, pcOut);
        end
        step();
    endtask

    task automatic test_flush();
        instr = 32'h14220004; pcIn = 32'h280; inValid = 1'b1; outReady = 1'b1;
        step();
        outReady = 1'b0;
        tests++;
        if (op !== 3'd1 || pcSrcCtrl !== 3'd3 || aluBSrcCtrl !== 1'b0 || regWe !== 1'b0) begin
            fails++;
            $display("FAIL bne: op=%0d pc=%0d alub=%b we=%b want 1 3 0 0", op, pcSrcCtrl, aluBSrcCtrl, regWe);
        end
        flush = 1'b1; instr = 32'h2022ffff; pcIn = 32'h300;
        #1;
        tests++;
        if (inReady !== 1'b0) begin
            fails++;
            $display("FAIL flush_inready: got %b want 0", inReady);
        end
        step();
        flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
        tests++;
        if (outValid !== 1'b0 || pcSrcCtrl !== 3'd3 || pcOut !== 32'h280) begin
            fails++;
            $display("FAIL flush: v=%b pcSrc=%0d pc=%h want 0 3 280", outValid, pcSrcCtrl, pcOut);
        end
        step();
        tests++;
        if (outValid !== 1'b0) begin
            fails++;
            $display("FAIL flush_noaccept: outValid=%b want 0", outValid);
        end
    endtask

    task automatic test_ori();
        instr = 32'h3422ffff; pcIn = 32'h400; inValid = 1'b1; outReady = 1'b1;
        step();
        inValid = 1'b0;
        tests++;
        if (imm !== 32'h0000ffff || op !== 3'd7 || illegal !== 1'b0 || regWe !== 1'b1) begin
            fails++;
            $display("FAIL ori_ext: imm=%h op=%0d ill=%b we=%b want 0000ffff 7 0 1", imm, op, illegal, regWe);
        end
        tests++;
        if (x_illegal !== 1'b1 || x_regWe !== 1'b0 || x_outValid !== 1'b1 || x_pcSrc !== 3'd0) begin
            fails++;
            $display("FAIL ori_base: ill=%b we=%b v=%b pcSrc=%0d want 1 0 1 0", x_illegal, x_regWe, x_outValid, x_pcSrc);
        end
        step();
    endtask

    task automatic test_back_to_back();
        inValid = 1'b1; outReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            instr = V_INSTR[i]; pcIn = 32'h500 + 32'(i * 4);
            step();
            tests++;
            if (outValid !== 1'b1 || op !== V_OP[i] || pcSrcCtrl !== V_PC[i] || regDInCtrl !== V_RD[i]
                || regWe !== V_WE[i] || regWAddr !== V_WR[i] || illegal !== V_ILL[i] || dmWe !== V_DM[i]
                || pcOut !== 32'h500 + 32'(i * 4)) begin
                fails++;
                $display("FAIL dec%0d: v=%b op=%0d pc=%0d rdin=%0d we=%b wr=%0d ill=%b dm=%b want 1 %0d %0d %0d %b %0d %b %b",
                         i, outValid, op, pcSrcCtrl, regDInCtrl, regWe, regWAddr, illegal, dmWe,
                         V_OP[i], V_PC[i], V_RD[i], V_WE[i], V_WR[i], V_ILL[i], V_DM[i]);
            end
            if (i == 2) begin
                tests++;
                if (jAddr !== 26'h10) begin
                    fails++;
                    $display("FAIL jal_jaddr: got %h want 0000010", jAddr);
                end
            end
        end
        inValid = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_reset_mid();
        test_load_use();
        test_backpressure();
        test_flush();
        test_ori();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
